// File: rtl/uart_inst_rx_if.sv
// Bus bundle between the UART byte source / sequencer and the instruction decoder.
// The master side drives received bytes and busy; the slave (decoder) returns instructions and status.
interface uart_inst_rx_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_seq_busy;
    logic [7:0] o_inst;
    logic       o_inst_valid;
    logic       o_fifo_full;
    logic       o_fifo_empty;
    logic       o_frame_err;
    logic [7:0] o_err_cnt;
    logic [7:0] o_inst_cnt;

    modport master (
        output i_rx_data, i_rx_valid, i_seq_busy,
        input  o_inst, o_inst_valid, o_fifo_full, o_fifo_empty,
               o_frame_err, o_err_cnt, o_inst_cnt
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_seq_busy,
        output o_inst, o_inst_valid, o_fifo_full, o_fifo_empty,
               o_frame_err, o_err_cnt, o_inst_cnt
    );
endinterface

// File: rtl/uart_inst_rx.sv
// Frames SYNC/INST/CHK byte packets from the UART receiver, queues good instructions
// and issues them to the sequencer as rate-limited one-cycle pulses.
module uart_inst_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] CHK_KEY        = 8'h5A,
    parameter int         FIFO_AW        = 2,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TO_W           = 20,
    parameter int         ISSUE_GAP      = 4
) (
    input  logic         clk,
    input  logic         arst_i,
    uart_inst_rx_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int GAP_W = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_INST, S_CHK} state_t;

    logic                rst_meta_reg, rst_reg;
    state_t              state_reg, state_next;
    logic [7:0]          inst_tmp_reg;
    logic [TO_W-1:0]     to_cnt_reg;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]    count_reg;
    logic [GAP_W-1:0]    gap_reg;
    logic [7:0]          inst_reg, err_cnt_reg, inst_cnt_reg;
    logic                inst_valid_reg, frame_err_reg;
    logic                timeout, chk_ok, full, empty, push, pop, capture, err_now;

    // Assert immediately, release synchronously two edges after arst_i drops.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            rst_meta_reg <= 1'b1;
            rst_reg      <= 1'b1;
        end else begin
            rst_meta_reg <= 1'b0;
            rst_reg      <= rst_meta_reg;
        end
    end

    assign full    = (count_reg == (FIFO_AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign timeout = (state_reg != S_IDLE) && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign chk_ok  = (bus.i_rx_data == (inst_tmp_reg ^ CHK_KEY));
    assign pop     = !empty && !bus.i_seq_busy && (gap_reg == '0);

    always_ff @(posedge clk or posedge rst_reg) begin
        if (rst_reg) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = S_IDLE;
        end else if (bus.i_rx_valid) begin
            case (state_reg)
                S_IDLE:  if (bus.i_rx_data == SYNC_BYTE) state_next = S_INST;
                S_INST:  state_next = S_CHK;
                S_CHK:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // A timeout wins over a byte arriving in the same cycle.
    always_comb begin
        capture = 1'b0;
        push    = 1'b0;
        err_now = timeout;
        if (!timeout && bus.i_rx_valid) begin
            if (state_reg == S_INST) capture = 1'b1;
            if (state_reg == S_CHK) begin
                push    = chk_ok && !full;
                err_now = !(chk_ok && !full);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst_reg) mem[wr_ptr_reg] <= inst_tmp_reg;
    end

    always_ff @(posedge clk or posedge rst_reg) begin
        if (rst_reg) begin
            inst_tmp_reg   <= '0;
            to_cnt_reg     <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            gap_reg        <= '0;
            inst_reg       <= '0;
            inst_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_cnt_reg    <= '0;
            inst_cnt_reg   <= '0;
        end else begin
            if (capture) inst_tmp_reg <= bus.i_rx_data;
            if (state_reg == S_IDLE || timeout || bus.i_rx_valid) to_cnt_reg <= '0;
            else                                                    to_cnt_reg <= to_cnt_reg + 1'b1;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            // Issue pacing: a pop reloads the gap, which must drain before the next pop.
            if (pop)               gap_reg <= GAP_W'(ISSUE_GAP);
            else if (gap_reg != 0) gap_reg <= gap_reg - 1'b1;
            if (pop) begin
                inst_reg     <= mem[rd_ptr_reg];
                inst_cnt_reg <= inst_cnt_reg + 8'd1;
            end
            inst_valid_reg <= pop;
            frame_err_reg  <= err_now;
            if (err_now && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign bus.o_inst       = inst_reg;
    assign bus.o_inst_valid = inst_valid_reg;
    assign bus.o_fifo_full  = full;
    assign bus.o_fifo_empty = empty;
    assign bus.o_frame_err  = frame_err_reg;
    assign bus.o_err_cnt    = err_cnt_reg;
    assign bus.o_inst_cnt   = inst_cnt_reg;
endmodule

// File: doc/uart_inst_rx.md
Name: uart_inst_rx

Overview:
Receive-side command decoder for the Nexys3 top. It consumes the byte stream delivered by the UART receiver (rx_data/rx_valid), frames 3-byte instruction packets, checks them, and buffers them in a small FIFO. It issues each instruction to the sequencer as an 8-bit word with a one-cycle valid pulse. This lets a host PC drive the sequencer over USB-UART instead of the switches and step button, complementing the existing sequencer-to-UART transmit path.

Parameters:
SYNC_BYTE, 8'hA5, packet header byte
CHK_KEY, 8'h5A, checksum key; a valid checksum equals inst ^ CHK_KEY
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between bytes inside a packet (10 ms at 100 MHz)
TO_W, 20, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
ISSUE_GAP, 4, minimum number of idle cycles between consecutive o_inst_valid pulses

Ports:
clk  in  1  100 MHz system clock
arst_i  in  1  reset, asynchronous, active-high
i_rx_data  in  8  received byte from the UART receiver
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle
i_seq_busy  in  1  high while the sequencer must not take a new instruction
o_inst  out  8  instruction word to the sequencer
o_inst_valid  out  1  one-cycle pulse; o_inst is valid in that cycle
o_fifo_full  out  1  FIFO holds 2**FIFO_AW entries
o_fifo_empty  out  1  FIFO holds 0 entries
o_frame_err  out  1  one-cycle pulse on any packet error
o_err_cnt  out  8  saturating packet-error count
o_inst_cnt  out  8  wrapping count of issued instructions

Behaviour:
- Reset: reset clk and arst_i, asynchronous, active-high. Internal rst is asserted asynchronously and released through a 2-flop synchronizer, so rst stays high 2 clk edges after arst_i falls.
- While rst is high:
  - outputs: o_inst=0, o_inst_valid=0, o_fifo_full=0, o_fifo_empty=1, o_frame_err=0, both counters=0;
  - FSM returns to S_IDLE; FIFO pointers, gap counter and timeout counter are cleared.
  - Reset mid-packet discards the partial packet and all FIFO contents.
- Byte framing FSM (advances only on cycles with i_rx_valid=1, except for timeout):
  - S_IDLE: byte==SYNC_BYTE -> S_INST. Any other byte is silently discarded: no error, no state change.
  - S_INST: capture byte into inst_tmp -> S_CHK. A byte equal to SYNC_BYTE is a legal instruction here.
  - S_CHK: byte==inst_tmp^CHK_KEY and FIFO not full -> push inst_tmp. If the checksum mismatches, or the FIFO is full (overflow, packet dropped) -> o_frame_err pulse. In every case -> S_IDLE.
  - Timeout: in S_INST/S_CHK the counter clears on each i_rx_valid and increments otherwise. When it reaches TIMEOUT_CYCLES-1 -> S_IDLE with o_frame_err pulse. A byte arriving in that same cycle is ignored.
- o_frame_err is registered: high in the cycle after the error-causing edge. o_err_cnt increments on each pulse and saturates at 255.
- FIFO:
  - push and pop in the same cycle are allowed; the count is unchanged;
  - full/empty are derived from an occupancy count of width FIFO_AW+1;
  - pushes never occur when full, because those packets are dropped upstream.
- Issue logic:
  - Pop occurs when !empty && !i_seq_busy && gap==0.
  - On pop, o_inst<=fifo head and o_inst_valid<=1 for exactly one cycle; gap<=ISSUE_GAP, decrementing to 0.
  - o_inst holds its last issued value between pulses.
  - o_inst_cnt increments with each pulse and wraps 255->0.
- Latency: with the FIFO empty, gap==0 and i_seq_busy=0, the checksum byte sampled at edge T writes the FIFO at T, pop is decided at T+1, and o_inst_valid is high in the cycle after edge T+1 (2-edge latency).
- i_seq_busy high blocks the pop and holds the FIFO contents. Packet reception continues while busy.
- i_rx_valid asserted on consecutive cycles is legal; one byte is processed per cycle.

Test Plan:
- After reset, send bytes A5,3C,66 (3C^5A=66) -> one o_inst_valid pulse 2 edges after the last byte with o_inst=8'h3C; o_inst_cnt=1; o_err_cnt=0.
- Send A5,3C,67 -> no issue; o_frame_err pulses once; o_err_cnt=1; a following A5,01,5B is issued correctly as 8'h01.
- Hold i_seq_busy=1 and send 5 valid packets with inst 10..14 -> o_fifo_full=1 after the 4th; the 5th gives an error (o_err_cnt=1). Release busy -> 10,11,12,13 are issued in order, pulses exactly ISSUE_GAP+1=5 cycles apart, then o_fifo_empty=1.
- Send A5,22 then idle 1,000,000 cycles -> o_frame_err pulse, FSM idle. A trailing byte 78 is discarded silently, and a subsequent A5,22,78 issues 8'h22.
- Send junk 00,FF, then A5,A5,FF (A5^5A=FF) -> a single issue with o_inst=8'hA5, no errors.
- Assert arst_i mid-packet with 2 entries queued -> outputs reset immediately; after release no o_inst_valid until a new full packet arrives. Also force 256 errors -> o_err_cnt saturates at 255.
